// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side bus of mem_arbiter. The slave modport is the
// arbiter's view; master is the view of the caches plus memory model.
interface mem_arbiter_if #(
  parameter int WORDS = 8
);
  localparam int OFF = $clog2(WORDS);

  logic           i_req;
  logic [15:0]    i_addr;
  logic           d_req;
  logic           d_wr;
  logic [15:0]    d_addr;
  logic [15:0]    d_wdata;
  logic           i_busy;
  logic           d_busy;
  logic           i_valid;
  logic           d_valid;
  logic [15:0]    fill_data;
  logic [OFF-1:0] fill_word;
  logic           i_done;
  logic           d_done;
  logic           wr_ack;
  logic           mem_en;
  logic           mem_wr;
  logic [15:0]    mem_addr;
  logic [15:0]    mem_wdata;
  logic [15:0]    mem_rdata;
  logic           mem_rvalid;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output i_busy, d_busy, i_valid, d_valid, fill_data, fill_word,
           i_done, d_done, wr_ack, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  i_busy, d_busy, i_valid, d_valid, fill_data, fill_word,
           i_done, d_done, wr_ack, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// I/D-cache arbiter for the shared pipelined memory port: block fills and
// single-word write-throughs. ARB_RR_EN selects round-robin I/D arbitration.
module mem_arbiter #(
  parameter int WORDS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);
  localparam int OFF   = $clog2(WORDS);
  localparam int BLK_W = 16 - OFF - 1;
  localparam logic [OFF-1:0] LAST = OFF'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, IFILL, DFILL, DWRITE} state_t;

  state_t           state_q, state_d;
  logic [OFF-1:0]   ic_q, ic_d;
  logic [OFF-1:0]   rc_q, rc_d;
  logic             issued_q, issued_d;
  logic [BLK_W-1:0] blk_q;
  logic [15:0]      waddr_q;
  logic [15:0]      wdata_q;

  logic d_side;
  logic pick_d;
  logic fill_act;
  logic issue;
  logic ret;
  logic last_ret;
  logic wr;
  logic unused_addr_bits;

  assign unused_addr_bits = ^bus.i_addr[OFF:0];
  assign d_side = bus.d_wr | bus.d_req;

`ifdef ARB_RR_EN
  logic last_d_q;

  // On a contest the side that did not win last time gets the port.
  assign pick_d = d_side & (~bus.i_req | ~last_d_q);
`else
  assign pick_d = d_side;
`endif

  assign fill_act = (state_q == IFILL) || (state_q == DFILL);
  assign issue    = fill_act & ~issued_q;
  assign ret      = fill_act & bus.mem_rvalid;
  assign last_ret = ret & (rc_q == LAST);
  assign wr       = (state_q == DWRITE);

  assign bus.i_busy    = (state_q == IFILL);
  assign bus.d_busy    = (state_q == DFILL) || wr;
  assign bus.i_valid   = ret & (state_q == IFILL);
  assign bus.d_valid   = ret & (state_q == DFILL);
  assign bus.i_done    = last_ret & (state_q == IFILL);
  assign bus.d_done    = last_ret & (state_q == DFILL);
  assign bus.fill_data = ret ? bus.mem_rdata : '0;
  assign bus.fill_word = ret ? rc_q : '0;
  assign bus.wr_ack    = wr;
  assign bus.mem_en    = issue | wr;
  assign bus.mem_wr    = wr;
  assign bus.mem_addr  = issue ? {blk_q, ic_q, 1'b0} : (wr ? waddr_q : '0);
  assign bus.mem_wdata = wr ? wdata_q : '0;

  always_comb begin
    state_d  = state_q;
    ic_d     = ic_q;
    rc_d     = rc_q;
    issued_d = issued_q;
    case (state_q)
      IDLE: begin
        if (pick_d && bus.d_wr)  state_d = DWRITE;
        else if (pick_d)         state_d = DFILL;
        else if (bus.i_req)      state_d = IFILL;
      end
      IFILL, DFILL: begin
        if (issue) begin
          ic_d = ic_q + 1'b1;
          if (ic_q == LAST) issued_d = 1'b1;
        end
        if (ret) rc_d = rc_q + 1'b1;
        // Last return ends the fill; issue is always finished by then.
        if (last_ret) begin
          state_d  = IDLE;
          ic_d     = '0;
          rc_d     = '0;
          issued_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ic_q     <= '0;
      rc_q     <= '0;
      issued_q <= 1'b0;
`ifdef ARB_RR_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ic_q     <= ic_d;
      rc_q     <= rc_d;
      issued_q <= issued_d;
`ifdef ARB_RR_EN
      if (state_q == IDLE && (d_side || bus.i_req)) last_d_q <= pick_d;
`endif
    end
  end

  // Request payload is sampled every idle cycle; the grant cycle's copy sticks.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      blk_q   <= pick_d ? bus.d_addr[15:OFF+1] : bus.i_addr[15:OFF+1];
      waddr_q <= bus.d_addr;
      wdata_q <= bus.d_wdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency (4) memory model and
// cache models that drop their request after done/wr_ack.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int WORDS = 8;
  localparam int LAT   = 4;
  localparam logic [7:0] G_D = 8'h44;
  localparam logic [7:0] G_I = 8'h49;
  localparam logic [7:0] G_W = 8'h57;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WORDS(WORDS)) bus();
  mem_arbiter #(.WORDS(WORDS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Memory model: read data is address ^ 0x5A5A, LAT cycles after issue.
  logic [LAT-1:0] pv_q;
  logic [15:0]    pa_q [LAT];
  logic           spur;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pv_q <= '0;
    else begin
      pv_q    <= {pv_q[LAT-2:0], bus.mem_en & ~bus.mem_wr};
      pa_q[0] <= bus.mem_addr;
      for (int k = 1; k < LAT; k++) pa_q[k] <= pa_q[k-1];
    end
  end

  assign bus.mem_rvalid = pv_q[LAT-1] | spur;
  assign bus.mem_rdata  = pv_q[LAT-1] ? (pa_q[LAT-1] ^ 16'h5A5A)
                                      : (spur ? 16'hDEAD : 16'h0000);

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  int i_ic, i_rc, d_ic, d_rc;
  int i_first, d_first, i_done_cyc, d_done_cyc, ack_cyc;
  logic [15:0] i_base, d_base, exp_waddr, exp_wdata;
  bit i_done_seen, d_done_seen, ack_seen, hold, i_rearm, d_rearm;
  bit prev_i_busy, prev_d_busy;
  logic [7:0] grants [$];

  task automatic clear_track();
    i_ic = 0; i_rc = 0; d_ic = 0; d_rc = 0;
    i_first = -1; d_first = -1; i_done_cyc = -1; d_done_cyc = -1; ack_cyc = -1;
    i_done_seen = 0; d_done_seen = 0; ack_seen = 0;
    i_rearm = 0; d_rearm = 0; prev_i_busy = 0; prev_d_busy = 0;
    grants.delete();
  endtask

  // One clock cycle: sample at the falling edge, check traffic, act as caches.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (i_rearm) begin bus.i_req = 1'b1; i_rearm = 0; end
    if (d_rearm) begin bus.d_req = 1'b1; d_rearm = 0; end
    if (bus.i_busy && !prev_i_busy) begin
      i_ic = 0; i_rc = 0; i_first = cyc; grants.push_back(G_I);
    end
    if (bus.d_busy && !prev_d_busy) begin
      d_ic = 0; d_rc = 0;
      if (!bus.mem_wr) d_first = cyc;
      grants.push_back(bus.mem_wr ? G_W : G_D);
    end
    if (bus.mem_en && !bus.mem_wr) begin
      if (bus.i_busy) begin
        check_eq("i_issue_addr", bus.mem_addr, i_base + 16'(2 * i_ic));
        i_ic++;
      end else begin
        check_eq("d_issue_addr", bus.mem_addr, d_base + 16'(2 * d_ic));
        d_ic++;
      end
    end
    if (bus.i_valid) begin
      check_eq("i_owner", bus.i_busy, 1);
      check_eq("i_fill_word", bus.fill_word, i_rc);
      check_eq("i_fill_data", bus.fill_data, (i_base + 16'(2 * i_rc)) ^ 16'h5A5A);
      if (bus.i_done) begin
        check_eq("i_done_word", i_rc, WORDS - 1);
        i_done_seen = 1; i_done_cyc = cyc; bus.i_req = 1'b0;
        if (hold) i_rearm = 1;
      end
      i_rc++;
    end
    if (bus.d_valid) begin
      check_eq("d_owner", bus.d_busy, 1);
      check_eq("d_fill_word", bus.fill_word, d_rc);
      check_eq("d_fill_data", bus.fill_data, (d_base + 16'(2 * d_rc)) ^ 16'h5A5A);
      if (bus.d_done) begin
        check_eq("d_done_word", d_rc, WORDS - 1);
        d_done_seen = 1; d_done_cyc = cyc; bus.d_req = 1'b0;
        if (hold) d_rearm = 1;
      end
      d_rc++;
    end
    if (bus.wr_ack) begin
      check_eq("wr_fields", {bus.mem_en, bus.mem_wr, bus.d_busy}, 3'b111);
      check_eq("wr_addr", bus.mem_addr, exp_waddr);
      check_eq("wr_data", bus.mem_wdata, exp_wdata);
      ack_seen = 1; ack_cyc = cyc; bus.d_wr = 1'b0;
    end
    prev_i_busy = bus.i_busy;
    prev_d_busy = bus.d_busy;
  endtask

  // which: 0 = i_done, 1 = d_done, 2 = wr_ack
  task automatic run_until(input string tag, input int which, input int limit);
    int n = 0;
    while (n < limit && !((which == 0) ? i_done_seen : (which == 1) ? d_done_seen : ack_seen)) begin
      step();
      n++;
    end
    check_eq(tag, n < limit, 1);
  endtask

  task automatic do_reset();
    bus.i_req = 0; bus.d_req = 0; bus.d_wr = 0;
    bus.i_addr = 0; bus.d_addr = 0; bus.d_wdata = 0;
    spur = 0; hold = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_track();
  endtask

  int t0;

  initial begin
    rst_n = 1'b0;
    do_reset();

    // Reset state
    step();
    check_eq("reset_ctrl", {bus.i_busy, bus.d_busy, bus.i_valid, bus.d_valid, bus.i_done,
                            bus.d_done, bus.wr_ack, bus.mem_en, bus.mem_wr}, 0);
    check_eq("reset_mem_addr", bus.mem_addr, 0);
    check_eq("reset_fill_data", bus.fill_data, 0);

    // I fill alone
    i_base = 16'h1230; bus.i_addr = 16'h1234; bus.i_req = 1'b1; t0 = cyc;
    run_until("t1_i_done_timeout", 0, 40);
    check_eq("t1_first_issue", i_first, t0 + 1);
    check_eq("t1_done_cycle", i_done_cyc, t0 + 12);
    check_eq("t1_issue_count", i_ic, 8);
    check_eq("t1_return_count", i_rc, 8);
    step();
    check_eq("t1_busy_after", bus.i_busy, 0);

    // D and I together: D first, block at top of address space
    do_reset();
    i_base = 16'h1230; bus.i_addr = 16'h1234;
    d_base = 16'hFFF0; bus.d_addr = 16'hFFFA;
    bus.i_req = 1'b1; bus.d_req = 1'b1; t0 = cyc;
    run_until("t2_d_done_timeout", 1, 40);
    check_eq("t2_d_first", d_first, t0 + 1);
    check_eq("t2_first_grant", grants[0], G_D);
    run_until("t2_i_done_timeout", 0, 40);
    check_eq("t2_i_after_d", i_first, d_done_cyc + 2);
    check_eq("t2_i_done_cycle", i_done_cyc, i_first + 11);

    // Write-through beats a pending I fill
    do_reset();
    exp_waddr = 16'h0040; exp_wdata = 16'hBEEF;
    bus.d_addr = 16'h0040; bus.d_wdata = 16'hBEEF; bus.d_wr = 1'b1;
    i_base = 16'h1230; bus.i_addr = 16'h1234; bus.i_req = 1'b1; t0 = cyc;
    run_until("t3_ack_timeout", 2, 5);
    check_eq("t3_ack_cycle", ack_cyc, t0 + 1);
    check_eq("t3_first_grant", grants[0], G_W);
    step();
    check_eq("t3_idle_after_wr", {bus.d_busy, bus.i_busy, bus.mem_en}, 0);
    run_until("t3_i_done_timeout", 0, 40);
    check_eq("t3_i_first", i_first, t0 + 3);

    // Both sides held continuously: grant order
    do_reset();
    hold = 1;
    i_base = 16'h1230; bus.i_addr = 16'h1234;
    d_base = 16'h0200; bus.d_addr = 16'h0200;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    for (int n = 0; n < 80 && grants.size() < 3; n++) step();
    check_eq("t4_grant_count", grants.size() >= 3, 1);
    if (grants.size() >= 3) begin
      check_eq("t4_grant0", grants[0], G_D);
`ifdef ARB_RR_EN
      check_eq("t4_grant1", grants[1], G_I);
`else
      check_eq("t4_grant1", grants[1], G_D);
`endif
      check_eq("t4_grant2", grants[2], G_D);
    end

    // Reset while word 3 is being returned, then refill from word 0
    do_reset();
    i_base = 16'h1230; bus.i_addr = 16'h1234; bus.i_req = 1'b1;
    for (int n = 0; n < 30 && i_rc < 4; n++) step();
    check_eq("t5_reached_word3", i_rc, 4);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t5_async_ctrl", {bus.i_busy, bus.i_valid, bus.i_done, bus.mem_en}, 0);
    check_eq("t5_async_addr", bus.mem_addr, 0);
    check_eq("t5_async_fill", {bus.fill_word, bus.fill_data}, 0);
    bus.i_req = 1'b0;
    step();
    rst_n = 1'b1;
    clear_track();
    bus.i_req = 1'b1; t0 = cyc;
    run_until("t5_refill_timeout", 0, 40);
    check_eq("t5_refill_first", i_first, t0 + 1);
    check_eq("t5_refill_done", i_done_cyc, t0 + 12);

    // Spurious mem_rvalid in IDLE
    do_reset();
    step();
    spur = 1'b1;
    #1;
    check_eq("t6_spur_valid", {bus.i_valid, bus.d_valid, bus.i_done, bus.d_done}, 0);
    check_eq("t6_spur_fill", {bus.fill_word, bus.fill_data}, 0);
    step();
    spur = 1'b0;
    check_eq("t6_spur_state", {bus.i_busy, bus.d_busy, bus.mem_en}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
